// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: owner state encoding,
// port indices and default bus widths.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int CORE = 0;
    localparam int ACC  = 1;

    localparam int DMEM_ADDR_WIDTH     = 10;
    localparam int DMEM_DATA_WIDTH     = 32;
    localparam int DMEM_TRANSFER_WIDTH = DMEM_DATA_WIDTH / 8;
    localparam int DMEM_MAX_BURST      = 8;
    localparam int BURST_CNT_WIDTH     = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick with a lock override that lets port 1 keep
// ownership until its burst limit is reached.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  arb_state_e last_owner,
    input  logic       lock,
    input  logic       burst_limit,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01: gnt[CORE] = 1'b1;
            2'b10: gnt[ACC]  = 1'b1;
            2'b11: begin
                // Locked engine bursts win until the limit; otherwise alternate,
                // with the core favoured when nobody owned the memory last.
                if (last_owner == OWN1 && lock && !burst_limit)
                    gnt[ACC] = 1'b1;
                else if (last_owner == OWN0)
                    gnt[ACC] = 1'b1;
                else
                    gnt[CORE] = 1'b1;
            end
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dataMem between the CPU load/store unit (port 0) and the matrix
// engine (port 1); grants are combinational, read data returns one cycle later.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DMEM_DATA_WIDTH,
    parameter int TRANSFER_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BURST      = DMEM_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      p0_req,
    input  logic                      p0_we,
    input  logic [ADDR_WIDTH-1:0]     p0_addr,
    input  logic [DATA_WIDTH-1:0]     p0_wdata,
    input  logic [TRANSFER_WIDTH-1:0] p0_wstrb,
    output logic                      p0_gnt,
    output logic                      p0_rvalid,
    output logic [DATA_WIDTH-1:0]     p0_rdata,

    input  logic                      p1_req,
    input  logic                      p1_we,
    input  logic [ADDR_WIDTH-1:0]     p1_addr,
    input  logic [DATA_WIDTH-1:0]     p1_wdata,
    input  logic [TRANSFER_WIDTH-1:0] p1_wstrb,
    input  logic                      p1_lock,
    output logic                      p1_gnt,
    output logic                      p1_rvalid,
    output logic [DATA_WIDTH-1:0]     p1_rdata,

    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [TRANSFER_WIDTH-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam logic [BURST_CNT_WIDTH-1:0] BURST_MAX = BURST_CNT_WIDTH'(MAX_BURST);

    arb_state_e                 state;
    arb_state_e                 state_next;
    logic [BURST_CNT_WIDTH-1:0] burst_cnt;
    logic                       burst_limit;
    logic [1:0]                 gnt;

    assign burst_limit = (burst_cnt >= BURST_MAX);

    rr_pick2 u_pick (
        .req         ({p1_req, p0_req}),
        .last_owner  (state),
        .lock        (p1_lock),
        .burst_limit (burst_limit),
        .gnt         (gnt)
    );

    assign p0_gnt = gnt[CORE];
    assign p1_gnt = gnt[ACC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (gnt[CORE])
            state_next = OWN0;
        else if (gnt[ACC])
            state_next = OWN1;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (gnt[CORE]) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wstrb = p0_wstrb;
        end else if (gnt[ACC]) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wstrb = p1_wstrb;
        end
    end

    // Counts only engine grants that made the core wait; any relief for the core clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            burst_cnt <= '0;
        else if (gnt[CORE] || !p0_req)
            burst_cnt <= '0;
        else if (gnt[ACC] && !burst_limit)
            burst_cnt <= burst_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= gnt[CORE] && !p0_we;
            p1_rvalid <= gnt[ACC] && !p1_we;
            if (gnt[CORE] && !p0_we)
                p0_rdata <= mem_rdata;
            if (gnt[ACC] && !p1_we)
                p1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-strobed memory model and a
// response scoreboard checked by an independent monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [9:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    resp_t       exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle_cnt = 0;
    logic        mem_init;
    logic [31:0] mem_words [0:255];

    localparam logic [9:0] A_X = 10'h010;
    localparam logic [9:0] A_Y = 10'h020;
    localparam logic [9:0] A_Z = 10'h030;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_wstrb  (p0_wstrb),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_wstrb  (p1_wstrb),
        .p1_lock   (p1_lock),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 256; w++) mem_words[w] <= 32'h0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem_words[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    assign mem_rdata = mem_words[mem_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0, input logic [3:0] s0,
        input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1, input logic [3:0] s1,
        input logic lk);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_wstrb = s0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_wstrb = s1;
        p1_lock = lk;
    endtask

    // Checks the grant and memory pins mid-cycle, queues the expected read
    // response, then advances to the next falling edge.
    task automatic checkOutput(input string name, input logic [1:0] exp_gnt, input logic [9:0] exp_addr,
                               input logic exp_we, input logic [31:0] exp_rd);
        resp_t r;
        #1;
        check({name, "_gnt"}, 32'({p1_gnt, p0_gnt}), 32'(exp_gnt));
        check({name, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        check({name, "_we"}, 32'(mem_we), 32'(exp_we));
        if (exp_gnt != 2'b00 && !exp_we) begin
            r.port = exp_gnt[1];
            r.data = exp_rd;
            r.cyc  = cycle_cnt + 1;
            exp_q.push_back(r);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (!rst && (p0_rvalid || p1_rvalid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'h0);
            end else begin
                r = exp_q.pop_front();
                check("rsp_onehot", 32'(p0_rvalid & p1_rvalid), 32'h0);
                check("rsp_port", 32'(p1_rvalid), 32'(r.port));
                check("rsp_data", r.port ? p1_rdata : p0_rdata, r.data);
                check("rsp_cycle", 32'(cycle_cnt), 32'(r.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_p0_rvalid", 32'(p0_rvalid), 0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_state", 32'(dut.state), 0);
        check("rst_burst", 32'(dut.burst_cnt), 0);
        rst = 1'b0;
        mem_init = 1'b0;

        // Writes, including a partial strobe and a zero-strobe write.
        applyStimulus(1, 1, A_X, 32'hA5A5_1234, 4'b0011, 0, 0, 0, 0, 0, 0);
        #1;
        check("wr0_wstrb", 32'(mem_wstrb), 32'h3);
        check("wr0_wdata", mem_wdata, 32'hA5A5_1234);
        checkOutput("wr0", 2'b01, A_X, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, A_Y, 32'hCAFE_F00D, 4'hF, 0);
        checkOutput("wr1", 2'b10, A_Y, 1, 0);
        applyStimulus(1, 1, A_Z, 32'h1122_3344, 4'hF, 0, 0, 0, 0, 0, 0);
        checkOutput("wr2", 2'b01, A_Z, 1, 0);
        applyStimulus(1, 0, A_X, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd0", 2'b01, A_X, 0, 32'h0000_1234);
        applyStimulus(1, 1, A_X, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wr0strb_wstrb", 32'(mem_wstrb), 32'h0);
        checkOutput("wr0strb", 2'b01, A_X, 1, 0);
        applyStimulus(1, 0, A_X, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd0_again", 2'b01, A_X, 0, 32'h0000_1234);

        // No request: everything to memory idles.
        applyStimulus(0, 1, A_Z, 32'hDEAD_BEEF, 4'hF, 0, 1, A_Y, 32'hDEAD_BEEF, 4'hF, 0);
        #1;
        check("idle_wstrb", 32'(mem_wstrb), 0);
        check("idle_wdata", mem_wdata, 0);
        checkOutput("idle", 2'b00, 0, 0, 0);

        // Unlocked contention from IDLE alternates.
        applyStimulus(1, 0, A_X, 0, 0, 1, 0, A_Y, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("alt_p0", 2'b01, A_X, 0, 32'h0000_1234);
            checkOutput("alt_p1", 2'b10, A_Y, 0, 32'hCAFE_F00D);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle2", 2'b00, 0, 0, 0);

        // Locked burst with MAX_BURST=4.
        applyStimulus(1, 0, A_Z, 0, 0, 1, 0, A_Y, 0, 0, 1);
        checkOutput("lk_first", 2'b01, A_Z, 0, 32'h1122_3344);
        for (int i = 0; i < 4; i++)
            checkOutput("lk_burst", 2'b10, A_Y, 0, 32'hCAFE_F00D);
        check("lk_burst_cnt", 32'(dut.burst_cnt), 4);
        checkOutput("lk_core", 2'b01, A_Z, 0, 32'h1122_3344);
        checkOutput("lk_again", 2'b10, A_Y, 0, 32'hCAFE_F00D);

        // Locked with no core pressure: unlimited engine grants, counter stays clear.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, A_Y, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("solo_p1", 2'b10, A_Y, 0, 32'hCAFE_F00D);
            check("solo_burst_cnt", 32'(dut.burst_cnt), 0);
        end

        // Reset in the cycle after an engine read grant drops the response.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, A_Y, 0, 0, 0);
        #1;
        check("rr_gnt", 32'({p1_gnt, p0_gnt}), 32'h2);
        @(posedge clk);
        #2;
        check("rr_pre_rvalid", 32'(p1_rvalid), 1);
        check("rr_pre_rdata", p1_rdata, 32'hCAFE_F00D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rr_rvalid", 32'(p1_rvalid), 0);
        check("rr_p1_rdata", p1_rdata, 0);
        check("rr_p0_rdata", p0_rdata, 0);
        check("rr_state", 32'(dut.state), 0);
        @(negedge clk);
        rst = 1'b0;

        // Post-reset contention starts from IDLE, so the core wins.
        applyStimulus(1, 0, A_X, 0, 0, 1, 0, A_Y, 0, 0, 0);
        checkOutput("post_rst", 2'b01, A_X, 0, 32'h0000_1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drain", 2'b00, 0, 0, 0);
        #1;
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared data memory (`dataMem`). It shares the memory between the CPU load/store unit (port 0) and the matrix-multiply engine (port 1), alternating on contention and supporting locked bursts for the engine. It drives the memory's write-enable, byte-strobe, address and data pins, and returns read data to the owning port as a registered response.

## Interface
- `ADDR_WIDTH`, 10, byte-address width, identical to the memory's.
- `DATA_WIDTH`, 32, word width.
- `TRANSFER_WIDTH`, 4, byte-strobe width (`DATA_WIDTH/8`).
- `MAX_BURST`, 8, maximum consecutive locked port-1 grants while port 0 is waiting; range 1..255.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `p0_req`, `p1_req`  in  1 each  access request; held with all fields stable until granted.
- `p0_we`, `p1_we`  in  1 each  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH each  byte address.
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH each  write data.
- `p0_wstrb`, `p1_wstrb`  in  TRANSFER_WIDTH each  byte enables; ignored for reads.
- `p1_lock`  in  1  keeps ownership with port 1 across consecutive requests.
- `p0_gnt`, `p1_gnt`  out  1 each  combinational; the access is performed in this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1 each  read data valid, registered.
- `p0_rdata`, `p1_rdata`  out  DATA_WIDTH each  registered read data.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`.
- `mem_wdata`  out  DATA_WIDTH  to memory `data_in`.
- `mem_wstrb`  out  TRANSFER_WIDTH  to memory `write_transfer_i`.
- `mem_rdata`  in  DATA_WIDTH  from memory `data_out`; combinational read.

## Operation
- FSM `state`: IDLE, OWN0, OWN1. `state` records the most recent owner; it drives round-robin priority.
- Winner selection is combinational, evaluated each cycle:
  - Only one port requests: that port wins.
  - Both request and `state`=OWN1 with `p1_lock`=1 and `burst_cnt` < MAX_BURST: port 1 wins.
  - Both request otherwise: the port not granted last wins. From IDLE, port 0 wins.
- Exactly one `pX_gnt` is high when any request is present. Never two.
- Memory pins follow the winner: `mem_addr`, `mem_wdata` and `mem_wstrb` come from the winner, and `mem_we` equals the winner's `we`.
- A grant with `we`=1 and `wstrb`=0 drives `mem_we`=1 and `mem_wstrb`=0, so no bytes are written. This is legal and no response is generated.
- No winner: `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
- State transitions:
  - Grant to port 0 → OWN0.
  - Grant to port 1 → OWN1.
  - No request → IDLE.
- `burst_cnt` (8 bit):
  - Increments on a port-1 grant while `p0_req`=1.
  - Saturates at MAX_BURST.
  - Clears on any port-0 grant, on any cycle with `p0_req`=0, and on IDLE.
- Read grant (`we`=0): `mem_rdata` is captured into the winner's `rdata`, and its `rvalid` pulses for 1 cycle.
- A port's `rdata` holds its value until that port's next read.
- Out-of-range addresses are passed through unchanged. The memory ignores those writes.

## Timing
- Grant latency: 0 cycles with no contention. Under contention, at most 1 access (unlocked) or MAX_BURST accesses (locked) of the other port.
- Write: completes at the rising edge closing the grant cycle. No response.
- Read: `pX_rvalid`/`pX_rdata` are valid in the cycle after the grant (1-cycle latency).
- Back-to-back grants to the same port are allowed every cycle, giving full throughput.
- Reset values: `state`=IDLE, `burst_cnt`=0, `p0_rvalid`=`p1_rvalid`=0, `p0_rdata`=`p1_rdata`=0. Combinational outputs follow the request inputs.
- Reset asserted mid-read: the pending `rvalid` is dropped and the requester must reissue the access.

## Structure
- Shared package `dmem_pkg`:
  - state encoding: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - port index constants: CORE=0, ACC=1.
  - default widths.
- Sub-module `rr_pick2`: combinational 2-way round-robin pick with lock override. Inputs are the two requests, last owner, lock, and burst-limit reached; output is the grant vector.

## Test plan
- Port 0 write addr 0x010, wdata 0xA5A5_1234, wstrb 4'b0011; then port 0 read addr 0x010 → `p0_gnt` in same cycle; next cycle `p0_rvalid`=1, `p0_rdata`=0x0000_1234.
- Both ports request reads every cycle from IDLE, unlocked → grants alternate p0, p1, p0, p1; each `rvalid` follows its grant by 1 cycle.
- MAX_BURST=4, `p1_lock`=1, both request continuously → 4 port-1 grants, then 1 port-0 grant, then port 1 again.
- `p1_lock`=1 with `p0_req` low for 10 cycles → 10 consecutive port-1 grants; `burst_cnt` stays 0.
- Assert `rst` in the cycle after a port-1 read grant → `p1_rvalid`=0, `state`=IDLE, rdata=0 immediately, asynchronous to `clk`.
- No requests → `mem_we`=0, `mem_wstrb`=0, both gnt=0; memory contents unchanged.
